mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences the core's single external memory port between two requesters: the instruction-fetch stage and the data (MEM) stage. It accepts held-level requests, arbitrates with data-side priority, drives the registered memory address/write interface, and returns one-cycle acknowledge pulses with read data. It sits between the pipeline stages and the `mem_addr`/`mem_wr_data`/`mem_wr_en`/`mem_rd_data` pins of ToastCore's memory interface.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MAX_STARVE`, 4: maximum number of consecutive data grants allowed while a fetch request waits. Used only with the configuration macro (see Configuration).
- `Clk` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `i_req` in 1: fetch request. Held high until `i_ack`.
- `i_addr` in ADDR_W: fetch address. Stable while `i_req` is high.
- `i_rdata` out DATA_W: fetch read data. Valid only while `i_ack` is high.
- `i_ack` out 1: one-cycle fetch-complete pulse.
- `i_stall` out 1: `i_req & ~i_ack`.
- `d_req` in 1: data request. Held until `d_ack`.
- `d_we` in 1: 1 = write, 0 = read. Stable while `d_req` is high.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: write data.
- `d_rdata` out DATA_W: data read data. Valid only while `d_ack` is high.
- `d_ack` out 1: one-cycle data-complete pulse. Pulses for reads and writes.
- `d_stall` out 1: `d_req & ~d_ack`.
- `mem_addr` out ADDR_W: registered memory address.
- `mem_wr_data` out DATA_W: registered write data.
- `mem_wr_en` out 1: registered write strobe.
- `mem_rst` out 1: equals `Reset`.
- `mem_rd_data` in DATA_W: memory read data. Synchronous memory: data is valid one cycle after the address is presented.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ADDR: memory address is driven.
  - DATA: read data arrives and the ack pulse is issued.
- Owner register `own` (I or D) is latched on the IDLE→ADDR transition.
- Arbitration in IDLE, on the same edge:
  - `d_req` wins over `i_req`.
  - With no request, remain in IDLE.
- On grant, register the owner's address into `mem_addr`.
  - Data writes also register `d_wdata` into `mem_wr_data` and set `mem_wr_en`=1.
  - Otherwise `mem_wr_en`=0.
- ADDR→DATA unconditionally. `mem_wr_en` clears on this edge, so it is high for exactly one cycle per write.
- DATA→IDLE unconditionally.
  - In DATA: `i_ack` = (own==I); `d_ack` = (own==D).
  - `i_rdata` and `d_rdata` pass `mem_rd_data` through combinationally.
  - For writes, `d_rdata` is don't-care.
- The requester deasserts `req` or changes the request on the edge after its ack. A req still high in IDLE after the ack cycle is a new request.
- `mem_addr` and `mem_wr_data` hold their last values in IDLE.
- Reset values:
  - state=IDLE, own=I.
  - `mem_addr`=0, `mem_wr_data`=0, `mem_wr_en`=0.
  - Starvation counter=0.
  - All acks=0.
- Reset mid-access: the transaction is abandoned, no ack is issued, and the requester re-presents it.
- Request dropped before ack: protocol violation. The access still completes and the ack still pulses; the bench flags it.

## Timing
- Request sampled high in IDLE at edge T:
  - `mem_addr` valid in cycle T+1.
  - `mem_wr_en` high in T+1 only, for writes.
  - Ack pulse in T+2.
  - FSM in IDLE at T+3.
- Latency is 2 cycles from the sampling edge to ack. Throughput is 1 access per 3 cycles.
- Simultaneous `i_req` and `d_req`: data completes at T+2, fetch is granted at T+3 and acks at T+5.
- `i_ack` and `d_ack` are never high in the same cycle.
- `i_stall`/`d_stall` are combinational from req and ack. No extra cycle.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A 3-bit saturating counter increments on each data grant made while `i_req` is high.
  - It clears on any fetch grant, and in IDLE whenever `i_req` is low.
  - When the counter equals `MAX_STARVE`, the next IDLE arbitration grants fetch even if `d_req` is high.
- Undefined: strict data priority. The counter is not implemented, and fetch can wait indefinitely under continuous `d_req`.

## Test plan
- Single fetch: `i_req`=1, `i_addr`=0x100, memory returns 0x00500093.
  - Expect `mem_addr`=0x100 at T+1.
  - Expect `i_ack`=1 with `i_rdata`=0x00500093 at T+2.
  - Expect no `d_ack`.
- Data write: `d_we`=1, `d_addr`=0x2004, `d_wdata`=0xDEADBEEF.
  - Expect `mem_wr_en`=1 for exactly one cycle, with `mem_addr`=0x2004 and `mem_wr_data`=0xDEADBEEF.
  - Expect `d_ack` at T+2.
- Collision: `i_req` and `d_req` (read 0x3000) rise together.
  - Expect `d_ack` at T+2 and `i_ack` at T+5.
  - Expect `i_stall`=1 for T through T+4.
- Starvation, guard enabled, `MAX_STARVE`=4: `d_req` continuously high, `i_req` high.
  - Expect exactly 4 `d_ack`, then 1 `i_ack`, then data resumes.
  - With the macro undefined: no `i_ack` within 40 cycles.
- Reset asserted at T+1 of a read to 0x40.
  - Expect immediate `mem_wr_en`=0, `mem_addr`=0, no ack, and state IDLE.
  - After release with req held, expect a full access with ack 2 cycles after the first sampling edge.
- Back-to-back fetches, `i_req` held and the address incremented after each ack.
  - Expect one ack every 3 cycles with the correct data per address.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-pin bundle of the shared memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  logic              i_stall;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              d_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_en;
  logic              mem_rst;
  logic [DATA_W-1:0] mem_rd_data;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd_data,
    output i_rdata, i_ack, i_stall, d_rdata, d_ack, d_stall,
           mem_addr, mem_wr_data, mem_wr_en, mem_rst
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd_data,
    input  i_rdata, i_ack, i_stall, d_rdata, d_ack, d_stall,
           mem_addr, mem_wr_data, mem_wr_en, mem_rst
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch/data arbiter for one synchronous memory port, data-side priority.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef MEM_ARB_STARVE_GUARD_EN
  , parameter int MAX_STARVE = 4
`endif
) (
  input logic               Clk,
  input logic               Reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t            r_state;
  logic              r_own_d;
  logic              r_wr_en;
  logic              r_i_ack;
  logic              r_d_ack;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_gnt_d;
  logic              w_gnt_i;
`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [2:0] r_starve;
  // once the fetch side has lost MAX_STARVE times in a row it wins the next arbitration
  assign w_gnt_d = bus.d_req & ~(bus.i_req & (r_starve == 3'(MAX_STARVE)));
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) r_starve <= '0;
    else if (r_state == IDLE)
      r_starve <= (w_gnt_i | ~bus.i_req) ? '0 :
                  (w_gnt_d && r_starve != 3'd7) ? r_starve + 3'd1 : r_starve;
`else
  assign w_gnt_d = bus.d_req;
`endif
  assign w_gnt_i = bus.i_req & ~w_gnt_d;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      r_state <= IDLE;
      r_own_d <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr_en <= 1'b0;
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_gnt_d | w_gnt_i) begin
          r_state <= ADDR;
          r_own_d <= w_gnt_d;
          r_addr  <= w_gnt_d ? bus.d_addr : bus.i_addr;
          r_wr_en <= w_gnt_d & bus.d_we;
          if (w_gnt_d & bus.d_we) r_wdata <= bus.d_wdata;
        end
        ADDR: begin
          r_state <= DATA;
          r_wr_en <= 1'b0;
          r_i_ack <= ~r_own_d;
          r_d_ack <= r_own_d;
        end
        default: begin
          r_state <= IDLE;
          r_i_ack <= 1'b0;
          r_d_ack <= 1'b0;
        end
      endcase
    end
  assign bus.mem_addr    = r_addr;
  assign bus.mem_wr_data = r_wdata;
  assign bus.mem_wr_en   = r_wr_en;
  assign bus.mem_rst     = Reset;
  assign bus.i_ack       = r_i_ack;
  assign bus.d_ack       = r_d_ack;
  assign bus.i_rdata     = bus.mem_rd_data;
  assign bus.d_rdata     = bus.mem_rd_data;
  assign bus.i_stall     = bus.i_req & ~r_i_ack;
  assign bus.d_stall     = bus.d_req & ~r_d_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter with a synchronous memory model.
module tb_mem_port_arbiter;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int nd_pre, nd_post, ni;
  mem_port_arbiter_if bus();
  mem_port_arbiter dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  function automatic logic [31:0] model(input logic [31:0] a);
    return (a == 32'h100) ? 32'h00500093 : (a ^ 32'h5A5A0000);
  endfunction
  initial bus.mem_rd_data = '0;
  always @(posedge Clk) bus.mem_rd_data <= model(bus.mem_addr);
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  initial begin
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    tick; tick;
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wr_data, 0);
    chk("rst_we", bus.mem_wr_en, 0);
    chk("rst_acks", {bus.i_ack, bus.d_ack}, 0);
    chk("rst_memrst", bus.mem_rst, 1);
    Reset = 0;
    tick;
    chk("memrst_low", bus.mem_rst, 0);
    bus.i_req = 1; bus.i_addr = 32'h100;
    tick;
    chk("f_addr", bus.mem_addr, 32'h100);
    chk("f_ack_early", bus.i_ack, 0);
    chk("f_stall", bus.i_stall, 1);
    tick;
    chk("f_ack", bus.i_ack, 1);
    chk("f_rdata", bus.i_rdata, 32'h00500093);
    chk("f_no_dack", bus.d_ack, 0);
    chk("f_stall_ack", bus.i_stall, 0);
    bus.i_req = 0;
    tick;
    chk("f_ack_clr", bus.i_ack, 0);
    chk("f_addr_hold", bus.mem_addr, 32'h100);
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2004; bus.d_wdata = 32'hDEADBEEF;
    tick;
    chk("w_we", bus.mem_wr_en, 1);
    chk("w_addr", bus.mem_addr, 32'h2004);
    chk("w_data", bus.mem_wr_data, 32'hDEADBEEF);
    chk("w_stall", bus.d_stall, 1);
    tick;
    chk("w_we_clr", bus.mem_wr_en, 0);
    chk("w_ack", {bus.i_ack, bus.d_ack}, 2'b01);
    chk("w_stall_ack", bus.d_stall, 0);
    bus.d_req = 0; bus.d_we = 0;
    tick;
    chk("w_ack_clr", bus.d_ack, 0);
    chk("w_we_idle", bus.mem_wr_en, 0);
    chk("w_data_hold", bus.mem_wr_data, 32'hDEADBEEF);
    bus.i_req = 1; bus.i_addr = 32'h104; bus.d_req = 1; bus.d_addr = 32'h3000;
    #1;
    chk("c_stall_T", {bus.i_stall, bus.d_stall}, 2'b11);
    tick;
    chk("c_addr_d", bus.mem_addr, 32'h3000);
    chk("c_stall_1", bus.i_stall, 1);
    tick;
    chk("c_dack", {bus.i_ack, bus.d_ack}, 2'b01);
    chk("c_drdata", bus.d_rdata, 32'h5A5A3000);
    chk("c_stall_2", bus.i_stall, 1);
    bus.d_req = 0;
    tick;
    chk("c_idle", {bus.i_ack, bus.d_ack}, 0);
    chk("c_stall_3", bus.i_stall, 1);
    tick;
    chk("c_addr_i", bus.mem_addr, 32'h104);
    chk("c_stall_4", bus.i_stall, 1);
    tick;
    chk("c_iack", {bus.i_ack, bus.d_ack}, 2'b10);
    chk("c_irdata", bus.i_rdata, 32'h5A5A0104);
    bus.i_req = 0;
    tick;
    bus.i_req = 1; bus.i_addr = 32'h40;
    tick;
    chk("r_addr_pre", bus.mem_addr, 32'h40);
    Reset = 1;
    #1;
    chk("r_we", bus.mem_wr_en, 0);
    chk("r_addr", bus.mem_addr, 0);
    chk("r_acks", {bus.i_ack, bus.d_ack}, 0);
    tick;
    chk("r_acks_hold", {bus.i_ack, bus.d_ack}, 0);
    Reset = 0;
    tick;
    chk("r_addr_again", bus.mem_addr, 32'h40);
    chk("r_no_ack", bus.i_ack, 0);
    tick;
    chk("r_ack", bus.i_ack, 1);
    chk("r_rdata", bus.i_rdata, 32'h5A5A0040);
    bus.i_req = 0;
    tick;
    bus.i_req = 1; bus.i_addr = 32'h200;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("b_addr", bus.mem_addr, 32'h200 + 32'(4 * k));
      tick;
      chk("b_ack", bus.i_ack, 1);
      chk("b_rdata", bus.i_rdata, model(32'h200 + 32'(4 * k)));
      bus.i_addr = bus.i_addr + 32'h4;
      if (k == 2) bus.i_req = 0;
      tick;
      chk("b_gap", bus.i_ack, 0);
    end
    nd_pre = 0; nd_post = 0; ni = 0;
    bus.i_req = 1; bus.i_addr = 32'h300; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h3010;
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int k = 1; k <= 18; k++) begin
      tick;
      chk("s_excl", bus.i_ack & bus.d_ack, 0);
      if (bus.i_ack) begin
        ni++;
        chk("s_irdata", bus.i_rdata, 32'h5A5A0300);
        bus.i_req = 0;
      end
      if (bus.d_ack) begin
        if (ni == 0) nd_pre++;
        else nd_post++;
      end
    end
    chk("s_d_before", nd_pre, 4);
    chk("s_i_count", ni, 1);
    chk("s_d_after", nd_post, 1);
`else
    for (int k = 1; k <= 40; k++) begin
      tick;
      chk("s_excl", bus.i_ack & bus.d_ack, 0);
      if (bus.i_ack) ni++;
      if (bus.d_ack) nd_pre++;
    end
    chk("s_no_iack", ni, 0);
    chk("s_d_count", nd_pre, 13);
    chk("s_i_stall", bus.i_stall, 1);
`endif
    bus.i_req = 0; bus.d_req = 0;
    tick; tick; tick;
    chk("end_idle", {bus.i_ack, bus.d_ack, bus.mem_wr_en}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
